collision_matrix_ctrl: RTL

COLLISION_MATRIX_CTRL -- requirements
Module: collision_matrix_ctrl

---
 rtl/collision_matrix_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/collision_matrix_ctrl.sv
// collision_matrix_ctrl: per-pair overlap detection with per-frame first-hit, pulse and count tracking.
module collision_matrix_ctrl #(
    parameter int NUM_OBJ = 4,
    parameter logic [NUM_OBJ*NUM_OBJ-1:0] PAIR_MASK = 16'h08CE,
    parameter int CNT_W = 4
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic [NUM_OBJ-1:0]           drawing_request,
    output logic                         collision,
    output logic                         SingleHitPulse,
    output logic [NUM_OBJ*NUM_OBJ-1:0]   pair_pulse,
    output logic [NUM_OBJ*NUM_OBJ-1:0]   pair_hits,
    output logic [NUM_OBJ*NUM_OBJ-1:0]   frame_hits,
    output logic [5:0]                   first_pair,
    output logic                         first_valid,
    output logic [CNT_W-1:0]             hit_count
);
    localparam int P = NUM_OBJ * NUM_OBJ;
    localparam logic [CNT_W+7:0] CMAX = {8'd0, {CNT_W{1'b1}}};
    logic [P-1:0]       ov, base, nw;
    logic [CNT_W-1:0]   cnt, cnt_base, cnt_nxt;
    logic [CNT_W+7:0]   sum;
    logic [6:0]         pop;
    logic [2:0]         fi, fj;
    logic               fire;
    always_comb begin
        ov = '0;
        for (int i = 0; i < NUM_OBJ; i++)
            for (int j = i + 1; j < NUM_OBJ; j++)
                ov[i*NUM_OBJ+j] = drawing_request[i] & drawing_request[j] & PAIR_MASK[i*NUM_OBJ+j];
    end
    // A frame start discards old hits first, so overlaps in that cycle count as new.
    assign base     = startOfFrame ? '0 : pair_hits;
    assign cnt_base = startOfFrame ? '0 : cnt;
    assign nw       = ov & ~base;
    assign fire     = (|nw) & ~(|base);
    always_comb begin
        pop = '0;
        fi  = '0;
        fj  = '0;
        for (int k = 0; k < P; k++)
            pop = pop + 7'(nw[k]);
        for (int k = P - 1; k >= 0; k--)
            if (nw[k]) begin
                fi = 3'(k / NUM_OBJ);
                fj = 3'(k % NUM_OBJ);
            end
    end
    assign sum     = {8'd0, cnt_base} + {{(CNT_W+1){1'b0}}, pop};
    assign cnt_nxt = (sum > CMAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collision      <= 1'b0;
            SingleHitPulse <= 1'b0;
            pair_pulse     <= '0;
            pair_hits      <= '0;
            frame_hits     <= '0;
            first_pair     <= '0;
            first_valid    <= 1'b0;
            hit_count      <= '0;
            cnt            <= '0;
        end else begin
            collision      <= |ov;
            SingleHitPulse <= fire;
            pair_pulse     <= nw;
            pair_hits      <= base | ov;
            cnt            <= cnt_nxt;
            first_valid    <= fire | (first_valid & ~startOfFrame);
            first_pair     <= fire ? {fi, fj} : (startOfFrame ? 6'd0 : first_pair);
            if (startOfFrame) begin
                frame_hits <= pair_hits;
                hit_count  <= cnt;
            end
        end
    end
endmodule
